// File: rtl/input_conditioner_pkg.sv
// Shared board defaults and constant helpers for the input conditioner slice.
package input_conditioner_pkg;

    localparam int NUM_BTN_DEF       = 4;
    localparam int NUM_SW_DEF        = 8;
    localparam int DEBOUNCE_CYC_DEF  = 1_000_000;
    localparam int REPEAT_DELAY_DEF  = 50_000_000;
    localparam int REPEAT_PERIOD_DEF = 10_000_000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) return a;
        else return b;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: two-flop synchroniser, mismatch counter, stable level and
// registered rise/fall pulses that coincide with the level change.
module input_conditioner_debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (clog2(DEBOUNCE_CYC) < 1) ? 1 : clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic          s1_r;
    logic          s2_r;
    logic          stable_r;
    logic          rise_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;
    logic          flip_s;

    // Flip once s2 has disagreed with the stable value for DEBOUNCE_CYC cycles.
    always_comb begin
        flip_s = 1'b0;
        if ((s2_r != stable_r) && (cnt_r == CNT_LAST)) flip_s = 1'b1;
        else flip_s = 1'b0;
    end

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
        end
    end

    // Mismatch counter, stable level and edge pulses; cnt never passes CNT_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            rise_r <= flip_s & ~stable_r;
            fall_r <= flip_s & stable_r;
            if (s2_r == stable_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (flip_s) begin
                cnt_r    <= {CW{1'b0}};
                stable_r <= ~stable_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = stable_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: debounced button/switch levels, press/release/change
// pulses and per-button auto-repeat pulses for the manager.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_BTN       = NUM_BTN_DEF,
    parameter int NUM_SW        = NUM_SW_DEF,
    parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] button,
    input  logic [NUM_SW-1:0]  switch,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [NUM_SW-1:0]  sw_level,
    output logic [NUM_SW-1:0]  sw_change
);

    localparam int RMAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RW   = (clog2(RMAX + 32'sd1) < 1) ? 1 : clog2(RMAX + 32'sd1);
    localparam logic [RW-1:0] ONE_V    = RW'(32'd1);
    localparam logic [RW-1:0] DELAY_V  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PERIOD_V = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] RMAX_V   = RW'(RMAX);
    localparam bit            REPEAT_EN = (REPEAT_DELAY != 32'sd0);

    logic [NUM_SW-1:0] sw_rise_s;
    logic [NUM_SW-1:0] sw_fall_s;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [RW-1:0] rcnt_r;
        logic [RW-1:0] rnxt_s;
        logic [RW-1:0] tgt_s;
        logic          per_r;
        logic          rep_r;

        input_conditioner_debounce_bit #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (button[i]),
            .level (btn_level[i]),
            .rise  (btn_press[i]),
            .fall  (btn_release[i])
        );

        // rcnt counts cycles since the press (or last repeat); the press cycle counts as 1.
        always_comb begin
            rnxt_s = rcnt_r;
            tgt_s  = DELAY_V;
            if (btn_press[i]) begin
                rnxt_s = ONE_V;
                tgt_s  = DELAY_V;
            end else begin
                if (rcnt_r == RMAX_V) rnxt_s = RMAX_V;
                else rnxt_s = rcnt_r + ONE_V;
                if (per_r) tgt_s = PERIOD_V;
                else tgt_s = DELAY_V;
            end
        end

        // Auto-repeat: first pulse after REPEAT_DELAY, then every REPEAT_PERIOD while held.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_r <= {RW{1'b0}};
                per_r  <= 1'b0;
                rep_r  <= 1'b0;
            end else if (!btn_level[i] || !REPEAT_EN) begin
                rcnt_r <= {RW{1'b0}};
                per_r  <= 1'b0;
                rep_r  <= 1'b0;
            end else if (rnxt_s == tgt_s) begin
                rcnt_r <= {RW{1'b0}};
                per_r  <= 1'b1;
                rep_r  <= 1'b1;
            end else begin
                rcnt_r <= rnxt_s;
                per_r  <= per_r & ~btn_press[i];
                rep_r  <= 1'b0;
            end
        end

        assign btn_repeat[i] = rep_r;
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        input_conditioner_debounce_bit #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (switch[i]),
            .level (sw_level[i]),
            .rise  (sw_rise_s[i]),
            .fall  (sw_fall_s[i])
        );
    end

    // Both pulse sources are flops, so the change pulse is glitch-free.
    assign sw_change = sw_rise_s | sw_fall_s;

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised scoreboard bench for input_conditioner with a windowed debounce model.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int NB = 4;
    localparam int NS = 8;
    localparam int NT = NB + NS;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic [NB-1:0] rep;
        logic [NS-1:0] swl;
        logic [NS-1:0] swc;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] button;
    logic [NS-1:0] switch;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [NS-1:0] sw_level, sw_change;

    input_conditioner #(
        .NUM_BTN       (NB),
        .NUM_SW        (NS),
        .DEBOUNCE_CYC  (D),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .button      (button),
        .switch      (switch),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   phase    = 0;
    obs_t exp_q[$];

    // directed captures
    int         press0_edge = -1;
    int         press1_cnt = 0, release1_cnt = 0;
    int         press2_edge = -1;
    int         rep2_q[$];
    int         press3_cnt = 0;
    logic [7:0] swc_q[$];
    int         swl_last = -1;

    task automatic check_int(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    // Reference model: a bit flips when the last D synchronised samples all differ from its level.
    initial begin : model
        logic [NT-1:0] hist [D+2];
        logic [NT-1:0] lvl_m, old, chg;
        int            press_at [NB];
        int            k;
        logic          steady;
        obs_t          e;
        k = 0;
        lvl_m = '0;
        for (int j = 0; j < D + 2; j++) hist[j] = '0;
        for (int b = 0; b < NB; b++) press_at[b] = -1;
        forever begin
            @(posedge clk);
            edge_cnt++;
            e = '0;
            if (!rst_n) begin
                for (int j = 0; j < D + 2; j++) hist[j] = '0;
                lvl_m = '0;
                for (int b = 0; b < NB; b++) press_at[b] = -1;
            end else begin
                k++;
                for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = {switch, button};
                old = lvl_m;
                for (int b = 0; b < NT; b++) begin
                    steady = 1'b1;
                    for (int j = 2; j <= D + 1; j++)
                        if (hist[j][b] == old[b]) steady = 1'b0;
                    if (steady) lvl_m[b] = ~old[b];
                end
                chg   = lvl_m ^ old;
                e.lvl = lvl_m[NB-1:0];
                e.prs = chg[NB-1:0] & lvl_m[NB-1:0];
                e.rel = chg[NB-1:0] & old[NB-1:0];
                e.swl = lvl_m[NT-1:NB];
                e.swc = chg[NT-1:NB];
                for (int b = 0; b < NB; b++) begin
                    e.rep[b] = old[b] && (press_at[b] >= 0) && (k - press_at[b] >= RD)
                               && (((k - press_at[b] - RD) % RP) == 0);
                    if (e.prs[b]) press_at[b] = k;
                    else if (!lvl_m[b]) press_at[b] = -1;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pop one expectation per cycle and compare away from the active edge.
    initial begin : monitor
        obs_t a, w;
        forever begin
            @(negedge clk);
            a = {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard empty @edge %0d: got %h, want an expectation", edge_cnt, a);
            end else begin
                w = exp_q.pop_front();
                if (!rst_n) w = '0;
                if (a !== w) begin
                    n_fail++;
                    $display("FAIL outputs @edge %0d: got %h, want %h", edge_cnt, a, w);
                end
            end
            if (phase == 2 && btn_press[0] && press0_edge < 0) press0_edge = edge_cnt;
            if (phase == 3 && btn_press[1]) press1_cnt++;
            if (phase == 3 && btn_release[1]) release1_cnt++;
            if (phase == 4 && btn_press[2] && press2_edge < 0) press2_edge = edge_cnt;
            if (phase == 4 && btn_repeat[2]) rep2_q.push_back(edge_cnt);
            if (phase == 6 && btn_press[3]) press3_cnt++;
            if (phase == 5 && sw_change != 8'h00) swc_q.push_back(sw_change);
            if (phase == 5) swl_last = int'(sw_level);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : driver
        int set_edge;
        rst_n  = 1'b0;
        button = '0;
        switch = '0;
        // 1: inputs toggle under reset, then release with inputs low
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            button = 4'($urandom);
            switch = 8'($urandom);
        end
        cyc(1);
        button = '0;
        switch = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(10);
        // 2: clean press latency
        phase = 2;
        button[0] = 1'b1;
        set_edge = edge_cnt;
        cyc(12);
        // 3: bounce then hold
        phase = 3;
        button[1] = 1'b1; cyc(2);
        button[1] = 1'b0; cyc(2);
        button[1] = 1'b1; cyc(2);
        button[1] = 1'b0; cyc(2);
        button[1] = 1'b1; cyc(20);
        // 4: long hold with auto-repeat, then release
        phase = 4;
        button[2] = 1'b1; cyc(45);
        button[2] = 1'b0; cyc(15);
        // random bouncing traffic
        phase = 0;
        for (int i = 0; i < 120; i++) begin
            button = 4'($urandom);
            switch = 8'($urandom);
            cyc($urandom_range(8, 1));
        end
        for (int i = 0; i < 15; i++) begin
            button = 4'($urandom);
            cyc($urandom_range(30, 10));
        end
        // 6: reset pulse during a hold
        button = 4'b1000;
        switch = '0;
        cyc(20);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        phase = 6;
        cyc(15);
        // 5: switches high from reset, then one switch drops
        phase = 0;
        rst_n  = 1'b0;
        button = '0;
        switch = 8'hA5;
        cyc(3);
        rst_n = 1'b1;
        phase = 5;
        cyc(12);
        switch = 8'h25;
        cyc(12);
        phase = 0;
        cyc(2);

        check_int("press latency", press0_edge - set_edge, D + 2);
        check_int("bounce press count", press1_cnt, 1);
        check_int("bounce release count", release1_cnt, 0);
        check_int("first repeat offset", (rep2_q.size() > 0) ? rep2_q[0] - press2_edge : -1, RD);
        check_int("repeat period", (rep2_q.size() > 1) ? rep2_q[1] - rep2_q[0] : -1, RP);
        check_int("repeat count", rep2_q.size(), 1 + (45 - RD) / RP);
        check_int("re-press after reset", press3_cnt, 1);
        check_int("sw_change count", swc_q.size(), 2);
        check_int("sw_change initial", (swc_q.size() > 0) ? int'(swc_q[0]) : -1, 'hA5);
        check_int("sw_change drop", (swc_q.size() > 1) ? int'(swc_q[1]) : -1, 'h80);
        check_int("sw_level final", swl_last, 'h25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
